// File: rtl/mdl_dmatiming_mc.sv
// mdl_dmatiming_mc: multi-channel round-robin DMA command timing sequencer
module mdl_dmatiming_mc #(
  parameter int CH = 2,
  parameter int ROT_LEN = 8,
  parameter int SAMPLE_PH = 3,
  parameter int ISSUE_PH = 6,
  parameter int CNT_W = 10,
  localparam int PW = $clog2(ROT_LEN),
  localparam int GW = $clog2(CH)
) (
  input  logic            i_MCLK,
  input  logic            i_SYS_RST_n,
  input  logic            i_CLK4M_PCEN_n,
  input  logic            i_SYNC,
  input  logic            i_ACC_ACT_n,
  input  logic            i_DMA_ACT,
  input  logic [2*CH-1:0] i_REQ_CMD,
  input  logic [CH-1:0]   i_LEN_LD,
  input  logic [CNT_W-1:0] i_LEN,
  output logic [PW-1:0]   o_PHASE,
  output logic            o_BR_START_n,
  output logic [CH-1:0]   o_CMD_ACK,
  output logic [GW-1:0]   o_GNT_CH,
  output logic            o_MSKADDR_INC,
  output logic            o_MSKREG_LD,
  output logic            o_DMADREG_BDHILO_LD,
  output logic [CH-1:0]   o_WORD_END,
  output logic [CH-1:0]   o_DMA_END
);
  typedef enum logic {OPEN, LOCK} lock_t;
  lock_t st, st_nx;
  logic en, at_s, at_i, ld0, found, dec;
  logic [GW-1:0] ptr, win, idx, s0_ch, s1_ch;
  logic [1:0] s0_cmd, s1_cmd;
  logic s0_v, s1_v;
  logic [CH-1:0] elig;
  logic [CNT_W-1:0] cnt [CH];

  assign en = ~i_CLK4M_PCEN_n;
  assign at_s = en && o_PHASE == PW'(SAMPLE_PH);
  assign at_i = en && o_PHASE == PW'(ISSUE_PH);
  assign ld0 = st == OPEN || !i_ACC_ACT_n;
  assign dec = at_i && s0_v && s0_cmd[0] && i_DMA_ACT;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    assign elig[c] = i_REQ_CMD[2*c +: 2] == 2'b10 || (i_REQ_CMD[2*c] && cnt[c] != '0);
    assign o_DMA_END[c] = cnt[c] == '0;
  end

  // round-robin: first eligible channel after the last winner
  always_comb begin
    found = 1'b0;
    win = '0;
    idx = '0;
    for (int k = 1; k <= CH; k++) begin
      idx = GW'((int'(ptr) + k) % CH);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end

  always_ff @(posedge i_MCLK or negedge i_SYS_RST_n)
    if (!i_SYS_RST_n) st <= OPEN;
    else st <= st_nx;

  always_comb begin
    st_nx = st;
    if (at_s) st_nx = !i_ACC_ACT_n ? OPEN : (|elig ? st : LOCK);
  end

  always_ff @(posedge i_MCLK or negedge i_SYS_RST_n) begin
    if (!i_SYS_RST_n) begin
      o_PHASE <= '0;
      o_BR_START_n <= 1'b1;
      o_CMD_ACK <= '0;
      o_WORD_END <= '0;
      ptr <= GW'(CH - 1);
      s0_v <= 1'b0;
      s0_ch <= '0;
      s0_cmd <= '0;
      s1_v <= 1'b0;
      s1_ch <= '0;
      s1_cmd <= '0;
      for (int c = 0; c < CH; c++) cnt[c] <= '0;
    end else if (en) begin
      o_PHASE <= i_SYNC || o_PHASE == PW'(ROT_LEN - 1) ? '0 : o_PHASE + 1'b1;
      o_CMD_ACK <= '0;
      o_WORD_END <= '0;
      if (at_s) begin
        o_BR_START_n <= !(|elig && ld0);
        if (ld0) begin
          s0_v <= found;
          if (found) begin
            s0_ch <= win;
            s0_cmd <= i_REQ_CMD[2*win +: 2];
            ptr <= win;
            o_CMD_ACK[win] <= 1'b1;
          end
        end
      end
      if (at_i) begin
        s1_v <= s0_v && st == OPEN;
        s1_ch <= s0_ch;
        s1_cmd <= s0_cmd;
      end
      // a same-edge length load overrides the decrement
      for (int c = 0; c < CH; c++) begin
        if (dec && s0_ch == GW'(c)) o_WORD_END[c] <= 1'b1;
        if (i_LEN_LD[c]) cnt[c] <= i_LEN;
        else if (dec && s0_ch == GW'(c) && cnt[c] != '0) cnt[c] <= cnt[c] - 1'b1;
      end
    end
  end

  assign o_GNT_CH = s1_ch;
  assign o_MSKADDR_INC = s1_v && i_DMA_ACT && s1_cmd == 2'b10;
  assign o_DMADREG_BDHILO_LD = s1_v && i_DMA_ACT && s1_cmd[0];
  assign o_MSKREG_LD = o_MSKADDR_INC && o_PHASE == PW'(SAMPLE_PH);
endmodule

// File: tb/tb_mdl_dmatiming_mc.sv
// tb_mdl_dmatiming_mc: directed self-checking bench for the DMA timing sequencer
module tb_mdl_dmatiming_mc;
  logic clk = 1'b0;
  logic rst_n, pcen_n, sync, acc_n, dma;
  logic [3:0] req;
  logic [1:0] len_ld;
  logic [9:0] len;
  logic [2:0] phase;
  logic br_n, gnt, msk_inc, mskreg_ld, dreg_ld;
  logic [1:0] ack, word_end, dma_end;
  int checks = 0;
  int failures = 0;
  int n;

  mdl_dmatiming_mc dut (
    .i_MCLK(clk),
    .i_SYS_RST_n(rst_n),
    .i_CLK4M_PCEN_n(pcen_n),
    .i_SYNC(sync),
    .i_ACC_ACT_n(acc_n),
    .i_DMA_ACT(dma),
    .i_REQ_CMD(req),
    .i_LEN_LD(len_ld),
    .i_LEN(len),
    .o_PHASE(phase),
    .o_BR_START_n(br_n),
    .o_CMD_ACK(ack),
    .o_GNT_CH(gnt),
    .o_MSKADDR_INC(msk_inc),
    .o_MSKREG_LD(mskreg_ld),
    .o_DMADREG_BDHILO_LD(dreg_ld),
    .o_WORD_END(word_end),
    .o_DMA_END(dma_end)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic goto_phase(input int p);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (phase !== 3'(p) && k < 20);
    chk("phase_wait", 32'(phase), p);
  endtask

  initial begin
    rst_n = 1'b0;
    pcen_n = 1'b0;
    sync = 1'b0;
    acc_n = 1'b0;
    dma = 1'b1;
    req = 4'b0000;
    len_ld = 2'b00;
    len = '0;
    repeat (2) @(negedge clk);
    chk("rst_phase", 32'(phase), 0);
    chk("rst_br", 32'(br_n), 1);
    chk("rst_dma_end", 32'(dma_end), 2'b11);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_strobes", {msk_inc, mskreg_ld, dreg_ld, word_end, gnt}, 0);
    // data transfer on ch0 with a two-word count
    len = 10'd2;
    len_ld = 2'b01;
    rst_n = 1'b1;
    @(negedge clk);
    chk("load_phase", 32'(phase), 1);
    chk("load_dma_end", 32'(dma_end), 2'b10);
    len_ld = 2'b00;
    req = 4'b0001;
    goto_phase(4);
    chk("r1_ack", 32'(ack), 2'b01);
    chk("r1_br", 32'(br_n), 0);
    chk("r1_dreg_early", 32'(dreg_ld), 0);
    goto_phase(7);
    chk("r1_word_end", 32'(word_end), 2'b01);
    chk("r1_dreg", 32'(dreg_ld), 1);
    chk("r1_gnt", 32'(gnt), 0);
    chk("r1_dma_end", 32'(dma_end), 2'b10);
    goto_phase(4);
    chk("r2_ack", 32'(ack), 2'b01);
    goto_phase(6);
    chk("r2_dreg_hold", 32'(dreg_ld), 1);
    chk("r2_we_idle", 32'(word_end), 0);
    goto_phase(7);
    chk("r2_word_end", 32'(word_end), 2'b01);
    chk("r2_dma_end", 32'(dma_end), 2'b11);
    goto_phase(4);
    chk("r3_no_ack", 32'(ack), 0);
    chk("r3_br", 32'(br_n), 1);
    goto_phase(7);
    chk("r3_dreg_off", 32'(dreg_ld), 0);
    // both channels requesting mask loads: grants alternate
    req = 4'b1010;
    goto_phase(4);
    chk("m1_ack", 32'(ack), 2'b10);
    goto_phase(7);
    chk("m1_msk_inc", 32'(msk_inc), 1);
    chk("m1_gnt", 32'(gnt), 1);
    chk("m1_mskreg_off", 32'(mskreg_ld), 0);
    chk("m1_dreg_off", 32'(dreg_ld), 0);
    chk("m1_we_off", 32'(word_end), 0);
    len = 10'd5;
    len_ld = 2'b10;
    @(negedge clk);
    len_ld = 2'b00;
    goto_phase(3);
    chk("m1_mskreg", 32'(mskreg_ld), 1);
    chk("m1_gnt_hold", 32'(gnt), 1);
    goto_phase(4);
    chk("m2_ack", 32'(ack), 2'b01);
    chk("m2_mskreg_off", 32'(mskreg_ld), 0);
    chk("m2_dma_end", 32'(dma_end), 2'b01);
    goto_phase(7);
    chk("m2_gnt", 32'(gnt), 0);
    chk("m2_msk_inc", 32'(msk_inc), 1);
    goto_phase(3);
    chk("m2_mskreg", 32'(mskreg_ld), 1);
    goto_phase(4);
    chk("m3_ack", 32'(ack), 2'b10);
    goto_phase(5);
    chk("pre_rst_msk_inc", 32'(msk_inc), 1);
    chk("pre_rst_br", 32'(br_n), 0);
    // asynchronous reset with strobes active
    rst_n = 1'b0;
    #1;
    chk("arst_phase", 32'(phase), 0);
    chk("arst_msk_inc", 32'(msk_inc), 0);
    chk("arst_br", 32'(br_n), 1);
    chk("arst_dma_end", 32'(dma_end), 2'b11);
    chk("arst_other", {ack, gnt, mskreg_ld, dreg_ld, word_end}, 0);
    // lock behaviour: idle bus with no requests
    req = 4'b0000;
    acc_n = 1'b1;
    len = 10'd5;
    len_ld = 2'b10;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    len_ld = 2'b00;
    goto_phase(4);
    chk("lk_br", 32'(br_n), 1);
    chk("lk_ack", 32'(ack), 0);
    req = 4'b0100;
    goto_phase(4);
    chk("lk_held_ack", 32'(ack), 0);
    chk("lk_held_br", 32'(br_n), 1);
    goto_phase(3);
    acc_n = 1'b0;
    goto_phase(4);
    chk("ul_ack", 32'(ack), 2'b10);
    chk("ul_br", 32'(br_n), 0);
    goto_phase(7);
    chk("ul_dreg", 32'(dreg_ld), 1);
    chk("ul_gnt", 32'(gnt), 1);
    chk("ul_word_end", 32'(word_end), 2'b10);
    chk("ul_dma_end", 32'(dma_end), 2'b01);
    // length load coinciding with a decrement of the same channel
    goto_phase(6);
    len = 10'd7;
    len_ld = 2'b10;
    @(negedge clk);
    len_ld = 2'b00;
    chk("ld_dec_we", 32'(word_end), 2'b10);
    n = 0;
    for (int r = 0; r < 10; r++) begin
      goto_phase(4);
      if (ack[1]) n++;
    end
    chk("ld_wins_grants", n, 7);
    chk("ld_wins_end", 32'(dma_end), 2'b11);
    // zero length makes the channel terminal immediately
    len = 10'd3;
    len_ld = 2'b10;
    @(negedge clk);
    chk("len3_dma_end", 32'(dma_end), 2'b01);
    len = 10'd0;
    @(negedge clk);
    chk("len0_dma_end", 32'(dma_end), 2'b11);
    len_ld = 2'b00;
    goto_phase(4);
    chk("len0_no_ack", 32'(ack), 0);
    chk("len0_br", 32'(br_n), 1);
    // sync and clock-enable freeze
    goto_phase(5);
    sync = 1'b1;
    @(negedge clk);
    chk("sync_phase", 32'(phase), 0);
    sync = 1'b0;
    req = 4'b0010;
    goto_phase(4);
    chk("fz_ack1", 32'(ack), 2'b01);
    goto_phase(7);
    chk("fz_msk_inc1", 32'(msk_inc), 1);
    chk("fz_gnt", 32'(gnt), 0);
    goto_phase(4);
    chk("fz_ack2", 32'(ack), 2'b01);
    pcen_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("frz_phase", 32'(phase), 4);
      chk("frz_ack", 32'(ack), 2'b01);
      chk("frz_msk_inc", 32'(msk_inc), 1);
    end
    pcen_n = 1'b0;
    @(negedge clk);
    chk("thaw_phase", 32'(phase), 5);
    chk("thaw_ack", 32'(ack), 0);
    chk("thaw_msk_inc", 32'(msk_inc), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
